// File: rtl/updown_counter_param.sv
// updown_counter_param: single-clock up/down LED counter.
// A prescaler issues a one-cycle TICK every DIV cycles; on each TICK the
// synchronised buttons may step the count by one. Supports parallel load,
// a global enable, wrap or saturate overflow handling and status flags.
module updown_counter_param #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DIV      = 125000000,
  parameter int unsigned SATURATE = 0
) (
  input  logic             CLOCK,
  input  logic             RES,
  input  logic             EN,
  input  logic [1:0]       BUTTONS,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] LEDS,
  output logic             TICK,
  output logic             AT_MAX,
  output logic             AT_MIN,
  output logic             OVF
);

  localparam int unsigned PW = $clog2(DIV);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] CMAX = '1;
  localparam logic [WIDTH-1:0] CMIN = '0;

  logic [1:0]       bmeta;
  logic [1:0]       bsync;
  logic [PW-1:0]    pcnt;
  logic [WIDTH-1:0] count;
  logic             ovf;
  logic             up_s;
  logic             dn_s;

  assign up_s = bsync[0];
  assign dn_s = bsync[1];

  // Two-flop synchroniser for the asynchronous push-buttons
  always_ff @(posedge CLOCK or negedge RES) begin
    if (!RES) begin
      bmeta <= '0;
      bsync <= '0;
    end else begin
      bmeta <= BUTTONS;
      bsync <= bmeta;
    end
  end

  // Prescaler: free-runs 0..DIV-1 while enabled, holds otherwise
  always_ff @(posedge CLOCK or negedge RES) begin
    if (!RES) begin
      pcnt <= '0;
    end else if (EN) begin
      if (pcnt == PMAX) pcnt <= '0;
      else              pcnt <= pcnt + PW'(1);
    end
  end

  assign TICK = EN & (pcnt == PMAX);

  // Count register: load beats tick-gated stepping; OVF flags a step past either end
  always_ff @(posedge CLOCK or negedge RES) begin
    if (!RES) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (LOAD) begin
      count <= LOAD_VAL;
      ovf   <= 1'b0;
    end else if (TICK && up_s && !dn_s) begin
      if (count == CMAX) begin
        count <= (SATURATE != 0) ? CMAX : CMIN;
        ovf   <= 1'b1;
      end else begin
        count <= count + WIDTH'(1);
        ovf   <= 1'b0;
      end
    end else if (TICK && dn_s && !up_s) begin
      if (count == CMIN) begin
        count <= (SATURATE != 0) ? CMIN : CMAX;
        ovf   <= 1'b1;
      end else begin
        count <= count - WIDTH'(1);
        ovf   <= 1'b0;
      end
    end else begin
      ovf <= 1'b0;
    end
  end

  assign LEDS   = count;
  assign OVF    = ovf;
  assign AT_MAX = (count == CMAX);
  assign AT_MIN = (count == CMIN);

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param (WIDTH=4, DIV=4): a wrapping
// instance and a saturating instance share the same stimulus.
module tb_updown_counter_param;

  logic       clk;
  logic       res;
  logic       en;
  logic [1:0] buttons;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] leds,  leds_s;
  logic       tick,  tick_s;
  logic       atmax, atmax_s;
  logic       atmin, atmin_s;
  logic       ovf,   ovf_s;

  int unsigned tests;
  int unsigned fails;

  updown_counter_param #(.WIDTH(4), .DIV(4), .SATURATE(0)) dut (
    .CLOCK(clk), .RES(res), .EN(en), .BUTTONS(buttons), .LOAD(load),
    .LOAD_VAL(load_val), .LEDS(leds), .TICK(tick), .AT_MAX(atmax),
    .AT_MIN(atmin), .OVF(ovf)
  );

  updown_counter_param #(.WIDTH(4), .DIV(4), .SATURATE(1)) dut_s (
    .CLOCK(clk), .RES(res), .EN(en), .BUTTONS(buttons), .LOAD(load),
    .LOAD_VAL(load_val), .LEDS(leds_s), .TICK(tick_s), .AT_MAX(atmax_s),
    .AT_MIN(atmin_s), .OVF(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Advance until TICK is high (bounded); leaves the bench inside the tick cycle
  task automatic wait_tick();
    int n;
    n = 0;
    while (!tick && n < 20) begin
      cyc();
      n++;
    end
    check("tick_seen", {31'b0, tick}, 32'd1);
  endtask

  logic [3:0] exp_w;
  logic [3:0] wrap_dn [1:3];

  initial begin
    tests = 0; fails = 0;
    res = 1'b0; en = 1'b1; buttons = 2'b00; load = 1'b0; load_val = 4'h0;
    wrap_dn[1] = 4'h0; wrap_dn[2] = 4'hF; wrap_dn[3] = 4'hE;

    // Reset state
    cyc(); cyc();
    check("rst_leds",  {28'b0, leds}, 32'd0);
    check("rst_atmin", {31'b0, atmin}, 32'd1);
    check("rst_atmax", {31'b0, atmax}, 32'd0);
    check("rst_ovf",   {31'b0, ovf}, 32'd0);
    check("rst_tick",  {31'b0, tick}, 32'd0);

    // Release reset: first TICK after the 3rd edge, then every 4 cycles
    res = 1'b1;
    cyc(); check("idle_tick1", {31'b0, tick}, 32'd0);
    cyc(); check("idle_tick2", {31'b0, tick}, 32'd0);
    cyc(); check("idle_tick3", {31'b0, tick}, 32'd1);
    cyc(); check("idle_tick4", {31'b0, tick}, 32'd0);
    cyc(); cyc();
    check("idle_tick6", {31'b0, tick}, 32'd0);
    cyc(); check("idle_tick7", {31'b0, tick}, 32'd1);
    check("idle_leds", {28'b0, leds}, 32'd0);
    cyc();

    // Up count with wrap: 17 ticks -> 1..15, 0, 1
    buttons = 2'b01;
    for (int k = 1; k <= 17; k++) begin
      wait_tick();
      cyc();
      exp_w = 4'(k);
      check("up_leds",  {28'b0, leds}, {28'b0, exp_w});
      check("up_ovf",   {31'b0, ovf}, (k == 16) ? 32'd1 : 32'd0);
      check("up_atmax", {31'b0, atmax}, (k == 15) ? 32'd1 : 32'd0);
    end

    // Both buttons: hold
    buttons = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_tick();
      cyc();
      check("both_hold", {28'b0, leds}, 32'd1);
    end

    // Release, then a one-cycle pulse landing just before the tick cycle
    buttons = 2'b00;
    wait_tick();
    cyc();
    check("rel_hold", {28'b0, leds}, 32'd1);
    cyc(); cyc();
    buttons = 2'b01;
    cyc();
    buttons = 2'b00;
    check("pulse_tickcyc", {31'b0, tick}, 32'd1);
    cyc();
    check("pulse_nostep1", {28'b0, leds}, 32'd1);
    wait_tick();
    cyc();
    check("pulse_nostep2", {28'b0, leds}, 32'd1);

    // LOAD coinciding with a tick while up is held
    buttons = 2'b01;
    wait_tick();
    load = 1'b1; load_val = 4'hA;
    cyc();
    load = 1'b0;
    check("load_leds", {28'b0, leds}, 32'hA);
    check("load_ovf",  {31'b0, ovf}, 32'd0);
    check("load_tick0", {31'b0, tick}, 32'd0);
    cyc(); check("load_tick1", {31'b0, tick}, 32'd0);
    cyc(); check("load_tick2", {31'b0, tick}, 32'd0);
    cyc(); check("load_tick3", {31'b0, tick}, 32'd1);
    cyc();
    check("load_step", {28'b0, leds}, 32'hB);

    // Enable low for 6 cycles mid-period
    cyc();
    en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      check("en_notick", {31'b0, tick}, 32'd0);
      check("en_frozen", {28'b0, leds}, 32'hB);
    end
    en = 1'b1;
    check("en_resume0", {31'b0, tick}, 32'd0);
    cyc(); check("en_resume1", {31'b0, tick}, 32'd0);
    cyc(); check("en_resume2", {31'b0, tick}, 32'd1);
    cyc();
    check("en_step", {28'b0, leds}, 32'hC);

    // Down through zero: saturate instance clamps, wrap instance wraps
    buttons = 2'b10;
    load = 1'b1; load_val = 4'h1;
    cyc();
    load = 1'b0;
    check("dn_load_w", {28'b0, leds},   32'd1);
    check("dn_load_s", {28'b0, leds_s}, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      wait_tick();
      cyc();
      check("dn_leds_s",  {28'b0, leds_s}, 32'd0);
      check("dn_ovf_s",   {31'b0, ovf_s}, (k >= 2) ? 32'd1 : 32'd0);
      check("dn_atmin_s", {31'b0, atmin_s}, 32'd1);
      check("dn_leds_w",  {28'b0, leds}, {28'b0, wrap_dn[k]});
      check("dn_ovf_w",   {31'b0, ovf}, (k == 2) ? 32'd1 : 32'd0);
    end

    // Up through max in both modes
    buttons = 2'b01;
    load = 1'b1; load_val = 4'hE;
    cyc();
    load = 1'b0;
    wait_tick();
    cyc();
    check("upsat1_s", {28'b0, leds_s}, 32'hF);
    check("upsat1_w", {28'b0, leds},   32'hF);
    check("upsat1_ovf", {31'b0, ovf_s}, 32'd0);
    wait_tick();
    cyc();
    check("upsat2_s",     {28'b0, leds_s}, 32'hF);
    check("upsat2_atmax", {31'b0, atmax_s}, 32'd1);
    check("upsat2_ovf_s", {31'b0, ovf_s}, 32'd1);
    check("upsat2_w",     {28'b0, leds}, 32'h0);
    check("upsat2_ovf_w", {31'b0, ovf}, 32'd1);

    // Asynchronous reset mid-cycle while OVF is high
    #2;
    res = 1'b0;
    #1;
    check("arst_leds_s", {28'b0, leds_s}, 32'd0);
    check("arst_ovf_s",  {31'b0, ovf_s}, 32'd0);
    check("arst_ovf_w",  {31'b0, ovf}, 32'd0);
    check("arst_atmin",  {31'b0, atmin_s}, 32'd1);
    check("arst_tick",   {31'b0, tick}, 32'd0);
    cyc();
    check("arst_hold", {28'b0, leds_s}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
